// File: rtl/pmem_pkg.sv
// Shared constants for the data-memory responder: access sizes, FSM state codes
// and the LFSR used by the optional random-latency build (PMEM_RAND_DELAY_EN).
package pmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/pmem_lane_align.sv
// Byte-lane steering between the right-justified register view and the word-wide
// array: store mask/data replication and load field extraction with extension.
module pmem_lane_align
  import pmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  // Select mask, replicated store data and extended load field for the access size.
  always_comb begin
    shifted   = rword >> {lane, 3'b000};
    wmask     = 4'hF;
    wdata_al  = wdata;
    rdata_ext = rword;
    case (size)
      SZ_B: begin
        wmask     = 4'b0001 << lane;
        wdata_al  = {4{wdata[7:0]}};
        rdata_ext = is_signed ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
      end
      SZ_H: begin
        wmask     = 4'b0011 << lane;
        wdata_al  = {2{wdata[15:0]}};
        rdata_ext = is_signed ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pmem_responder.sv
// Memory-side responder for the CPU data port: one request at a time, response
// after a programmable latency. Defining PMEM_RAND_DELAY_EN replaces the fixed
// LATENCY with a per-request LFSR-derived latency of 1..8 cycles.
//
//   state | meaning
//   IDLE  | ready for a new request
//   BUSY  | request latched, counting down latency
//   RESP  | response presented, waiting for rsp_ready
module pmem_responder
  import pmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 16384,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // Wide enough for LATENCY and for the 1..8 random latency.
  localparam int CNT_W = $clog2(LATENCY + 9);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] acc_lat;

  logic             lat_wen, lat_err, lat_signed;
  logic [IDX_W-1:0] lat_idx;
  logic [1:0]       lat_lane, lat_size;
  logic [31:0]      lat_wdata;

  logic [31:0] offset;
  logic        range_err, align_err, busy_done, mem_we;
  logic [3:0]  wmask;
  logic [31:0] wdata_al, rdata_ext;

  assign req_ready = rst && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy_done = (state == BUSY) && (cnt == CNT_W'(1));
  assign mem_we    = rst && busy_done && lat_wen && !lat_err;

  // Unsigned subtract; the explicit below-base test rules out wrap-around hits.
  assign offset    = req_addr - BASE_ADDR;
  assign range_err = (req_addr < BASE_ADDR) || ((offset >> 2) >= 32'(DEPTH_WORDS));

  // Misalignment and illegal-size detection.
  always_comb begin
    align_err = 1'b0;
    case (req_size)
      SZ_B:    align_err = 1'b0;
      SZ_H:    align_err = req_addr[0];
      SZ_W:    align_err = (req_addr[1:0] != 2'b00);
      default: align_err = 1'b1;
    endcase
  end

`ifdef PMEM_RAND_DELAY_EN
  logic [15:0] lfsr;

  // LFSR advances once per accepted request; the pre-step value sets its latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else if (req_valid && req_ready) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign acc_lat = CNT_W'(lfsr[2:0]) + CNT_W'(1);
`else
  assign acc_lat = CNT_W'(LATENCY);
`endif

  pmem_lane_align u_align (
    .size      (lat_size),
    .lane      (lat_lane),
    .is_signed (lat_signed),
    .wdata     (lat_wdata),
    .rword     (mem[lat_idx]),
    .wmask     (wmask),
    .wdata_al  (wdata_al),
    .rdata_ext (rdata_ext)
  );

  // FSM, latency counter, request latch and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      lat_wen    <= 1'b0;
      lat_err    <= 1'b0;
      lat_signed <= 1'b0;
      lat_idx    <= '0;
      lat_lane   <= '0;
      lat_size   <= '0;
      lat_wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state      <= BUSY;
          cnt        <= acc_lat;
          lat_wen    <= req_wen;
          lat_err    <= range_err || align_err;
          lat_signed <= req_signed;
          lat_idx    <= offset[IDX_W+1:2];
          lat_lane   <= req_addr[1:0];
          lat_size   <= req_size;
          lat_wdata  <= req_wdata;
        end
        BUSY: if (busy_done) begin
          state     <= RESP;
          cnt       <= '0;
          rsp_err   <= lat_err;
          rsp_rdata <= (lat_err || lat_wen) ? 32'h0 : rdata_ext;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-masked array write on the BUSY->RESP edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[lat_idx][8*i +: 8] <= wdata_al[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Randomized and directed checks of pmem_responder against a byte-level
// behavioural memory model. Honours PMEM_RAND_DELAY_EN for latency expectations.
module tb_pmem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 16384;
  localparam int          LAT   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_wen = 1'b0, req_signed = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int vectors = 0;
  int miscompares = 0;

  bit [7:0]  mem_m [longint];
  bit [15:0] lfsr_m = 16'hACE1;

  pmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [31:0] addr, input logic [1:0] size);
    longint off;
    off = longint'(addr) - longint'(BASE);
    if (size == 2'd3) return 1;
    if (addr % nbytes(size) != 0) return 1;
    if (off < 0) return 1;
    if (off / 4 >= DEPTH) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input bit sgn);
    longint v = 0;
    int n = nbytes(size);
    for (int k = 0; k < n; k++) begin
      longint a = longint'(addr) + k;
      v += (mem_m.exists(a) ? longint'(mem_m[a]) : 0) << (8 * k);
    end
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] wdata);
    for (int k = 0; k < nbytes(size); k++)
      mem_m[longint'(addr) + k] = wdata[8*k +: 8];
  endtask

  function automatic int next_lat();
`ifdef PMEM_RAND_DELAY_EN
    int l;
    bit fb;
    l  = 1 + (lfsr_m % 8);
    fb = lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10];
    lfsr_m = {lfsr_m[14:0], fb};
    return l;
`else
    return LAT;
`endif
  endfunction

  // One full transaction: accept, wait for response, optional back-pressure, handshake.
  task automatic xact(input string tag, input bit wen, input logic [31:0] addr,
                      input logic [1:0] size, input bit sgn, input logic [31:0] wdata,
                      input int hold);
    logic [31:0] exp_d;
    bit exp_e;
    int exp_lat, lat;
    exp_e   = model_err(addr, size);
    exp_d   = (exp_e || wen) ? 32'h0 : model_load(addr, size, sgn);
    exp_lat = next_lat();
    @(negedge clk);
    chk({tag, ".req_ready"}, {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (wen && !exp_e) model_store(addr, size, wdata);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".rdata"}, rsp_rdata, exp_d);
    chk({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_e});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, {31'h0, rsp_valid}, 32'd1);
      chk({tag, ".hold_rdata"}, rsp_rdata, exp_d);
      chk({tag, ".hold_err"}, {31'h0, rsp_err}, {31'h0, exp_e});
      chk({tag, ".hold_req_ready"}, {31'h0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".post_valid"}, {31'h0, rsp_valid}, 32'd0);
    chk({tag, ".post_req_ready"}, {31'h0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] addr;
    logic [1:0]  size;
    int w;

    #12;
    chk("reset.req_ready", {31'h0, req_ready}, 32'd0);
    chk("reset.rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("reset.rdata", rsp_rdata, 32'h0);
    chk("reset.err", {31'h0, rsp_err}, 32'd0);
    @(negedge clk); rst = 1'b1;

    xact("st_word", 1, BASE, 2'd2, 0, 32'hDEADBEEF, 0);
    xact("ld_word", 0, BASE, 2'd2, 0, 32'h0, 0);
    xact("st_byte", 1, BASE + 2, 2'd0, 0, 32'h000000A5, 0);
    xact("ld_word2", 0, BASE, 2'd2, 0, 32'h0, 0);
    xact("ld_sbyte", 0, BASE + 2, 2'd0, 1, 32'h0, 0);
    xact("ld_ubyte", 0, BASE + 2, 2'd0, 0, 32'h0, 0);
    xact("ld_shalf", 0, BASE + 2, 2'd1, 1, 32'h0, 0);
    xact("ld_half_mis", 0, BASE + 1, 2'd1, 0, 32'h0, 0);
    xact("st_word_mis", 1, BASE + 6, 2'd2, 0, 32'h11223344, 0);
    xact("ld_after_mis", 0, BASE + 4, 2'd2, 0, 32'h0, 0);
    xact("size_ill", 0, BASE, 2'd3, 0, 32'h0, 0);
    xact("ld_below", 0, 32'h7FFF_FFFC, 2'd2, 0, 32'h0, 0);
    xact("ld_past", 0, BASE + 4 * DEPTH, 2'd2, 0, 32'h0, 0);
    xact("st_last", 1, BASE + 4 * (DEPTH - 1), 2'd2, 0, 32'hCAFEF00D, 0);
    xact("ld_last", 0, BASE + 4 * (DEPTH - 1), 2'd2, 0, 32'h0, 0);
    xact("backpress", 0, BASE, 2'd2, 0, 32'h0, 5);

    // Reset during BUSY drops the store.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE; req_size = 2'd2;
    req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst.req_ready", {31'h0, req_ready}, 32'd0);
    chk("midrst.rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("midrst.rdata", rsp_rdata, 32'h0);
    chk("midrst.err", {31'h0, rsp_err}, 32'd0);
    @(negedge clk); rst = 1'b1;
    lfsr_m = 16'hACE1;
    xact("ld_after_rst", 0, BASE, 2'd2, 0, 32'h0, 0);

    for (int i = 0; i < 8; i++)
      xact("rnd_init", 1, BASE + 4 * i, 2'd2, 0, $urandom, 0);
    for (int i = 0; i < 100; i++) begin
      w    = $urandom_range(0, 7);
      size = 2'($urandom_range(0, 3));
      addr = BASE + 4 * w + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) addr = ($urandom_range(0, 1) == 1) ? addr - 32'h100 : addr + 4 * DEPTH;
      xact("rnd", 1'($urandom_range(0, 1)), addr, size, 1'($urandom_range(0, 1)), $urandom,
           $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
